// File: rtl/register_serial_unload.sv
// Parallel-load, MSB-first serial-unload register with valid/ready on both sides.
// Define UNLOAD_PARITY_EN to append an even-parity bit after the data bits.
module register_serial_unload #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] I,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef UNLOAD_PARITY_EN
    PARITY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [N-1:0]  sh;
  logic [N-1:0]  sh_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
`ifdef UNLOAD_PARITY_EN
  logic          par;
  logic          par_n;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
`ifdef UNLOAD_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
`ifdef UNLOAD_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    sh_n       = sh;
    cnt_n      = cnt;
`ifdef UNLOAD_PARITY_EN
    par_n      = par;
`endif
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sh_n    = I;
          cnt_n   = '0;
`ifdef UNLOAD_PARITY_EN
          par_n   = ^I;
`endif
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sout       = sh[N-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (sout_ready) begin
          sh_n = {sh[N-2:0], 1'b0};
          // cnt rolls back to zero only on leaving SHIFT
          if (cnt == LAST) begin
            cnt_n = '0;
`ifdef UNLOAD_PARITY_EN
            state_n = PARITY;
`else
            state_n = DONE;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`ifdef UNLOAD_PARITY_EN
      PARITY: begin
        sout       = par;
        sout_valid = 1'b1;
        busy       = 1'b1;
        if (sout_ready) begin
          state_n = DONE;
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/register_serial_unload.md
# register_serial_unload

Parallel-load, serial-unload register. It captures an N-bit word through a valid/ready load handshake, then shifts it out one bit per accepted transfer, MSB first, under a serial valid/ready handshake. It sits on the read side of the N-bit parallel-load registers in the storage path: it drains a stored word onto a 1-bit link toward a downstream serial consumer.

## Interface
- N, default 4: data word width; legal N ≥ 2.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  producer offers I this cycle.
- load_ready  output  1  block can accept a word (IDLE only).
- I  input  N  parallel word to serialize.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit.
- sout_ready  input  1  consumer accepts sout this cycle.
- busy  output  1  frame in progress (SHIFT or PARITY state).
- done  output  1  one-cycle pulse after the final bit of a frame is accepted.

## Operation
- State registers: state (IDLE, SHIFT, PARITY, DONE), shift register sh[N-1:0], bit counter cnt of width $clog2(N), and parity accumulator par.
- IDLE: load_ready=1, sout_valid=0, busy=0. When load_valid & load_ready at a clock edge: sh<=I, cnt<=0, par<=^I, next state SHIFT. When load_valid=0, hold IDLE.
- SHIFT: sout=sh[N-1], sout_valid=1, busy=1, load_ready=0. On each edge with sout_ready=1: sh<=sh<<1, cnt<=cnt+1. When cnt==N-1 and sout_ready=1, next state is PARITY if UNLOAD_PARITY_EN is defined, otherwise DONE. With sout_ready=0, sh, cnt and sout hold.
- PARITY (compiled in only): sout=par, sout_valid=1, busy=1. On sout_ready=1, next state DONE. Otherwise hold.
- DONE: done=1, sout_valid=0, busy=0, load_ready=0 for exactly one cycle, then IDLE.
- load_valid is ignored outside IDLE. I is sampled only on the accepting edge, so later changes to I do not affect the frame in flight.
- sout is 0 whenever sout_valid=0.
- Reset (asynchronous, any state, including mid-frame): state=IDLE, sh=0, cnt=0, par=0. Output values: load_ready=1, sout=0, sout_valid=0, busy=0, done=0. The aborted frame produces no done pulse.

## Timing
- Load accepted at edge k: first bit (I[N-1]) appears with sout_valid=1 in the cycle after edge k.
- Frame length is N accepted transfers (N+1 with parity). With sout_ready held at 1, the bits occupy cycles k+1..k+N (k+N+1 with parity).
- done is high in the cycle after the edge that accepts the final bit. load_ready returns high in the next cycle.
- Minimum word-to-word period is N+2 cycles (N+3 with parity). Back-to-back loads are not overlapped.
- A stall (sout_ready=0) extends the frame cycle-for-cycle. sout and sout_valid stay stable while stalled; sout_valid never drops mid-frame.
- cnt wraps only through the state transition; it never exceeds N-1.

## Configuration
- Macro UNLOAD_PARITY_EN.
- When defined: an even-parity bit (XOR of all N data bits) is appended after the data bits via the PARITY state.
- When undefined: the PARITY state, the par register and the extra transfer are absent. SHIFT goes straight to DONE and the frame is exactly N bits.

## Test plan
- Reset: drive reset_n=0 mid-cycle with no clock edge. Required: outputs go immediately to load_ready=1, sout=0, sout_valid=0, busy=0, done=0.
- Basic frame, N=4, I=4'b1011, sout_ready=1: sout sequence 1,0,1,1 on four consecutive cycles. With UNLOAD_PARITY_EN defined, a fifth bit 1 follows. done pulses once, then load_ready=1.
- Stall: I=4'b0110, sout_ready=0 for 2 cycles on the second bit. Required: sout holds 1 with sout_valid=1 for 3 cycles, and the full sequence 0,1,1,0 is delivered intact.
- Busy load ignore: pulse load_valid with I=4'b1111 during a frame of 4'b1000. Required: the output stays 1,0,0,0 and the second word is not captured.
- Reset mid-frame: assert reset_n=0 after 2 bits of 4'b1010. Required: immediate return to IDLE with no done pulse. The next load of 4'b0011 yields 0,0,1,1.
- Back-to-back: load_valid held high with 4'b1100 then 4'b0101. Required: the frames are separated by exactly one DONE cycle plus one IDLE accept cycle, and each frame is output in order.
